// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type and width helpers for the streaming
// convolution engine.
//   state_e    - engine state: IDLE, RUN, FLUSH
//   clog2      - ceiling log2 (clog2(1) = 0)
//   addr_width - tap-index width, never below 1 bit
//   acc_width  - full-precision output width for a given geometry
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int addr_width(input int taps);
    return (clog2(taps) < 1) ? 1 : clog2(taps);
  endfunction

  // Sum of TAPS products of DATA_W x COEF_W bits grows by clog2(TAPS) bits.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

endpackage

// File: rtl/conv_mac_tree.sv
// conv_mac_tree: combinational multiply of TAPS sample/coefficient pairs
// followed by a balanced binary adder tree.
//   samples_i - delay-line contents, element k multiplies coefs_i[k]
//   coefs_i   - kernel coefficients
//   sum_o     - full-precision sum, ACC_W bits
module conv_mac_tree
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter bit SIGNED = 1'b1,
  parameter int ACC_W  = acc_width(DATA_W, COEF_W, TAPS)
) (
  input  logic [TAPS-1:0][DATA_W-1:0] samples_i,
  input  logic [TAPS-1:0][COEF_W-1:0] coefs_i,
  output logic [ACC_W-1:0]            sum_o
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int EXT_W  = ACC_W - PROD_W;
  localparam int LEVELS = clog2(TAPS);
  localparam int LEAVES = 1 << LEVELS;

  logic [LEAVES-1:0][ACC_W-1:0] prod;
  logic [ACC_W-1:0]             node [2*LEAVES-1];

  for (genvar gi = 0; gi < LEAVES; gi++) begin : g_prod
    if (gi < TAPS) begin : g_tap
      logic [PROD_W-1:0] d_ext;
      logic [PROD_W-1:0] c_ext;
      logic [PROD_W-1:0] p;
      if (SIGNED) begin : g_sext
        assign d_ext = {{COEF_W{samples_i[gi][DATA_W-1]}}, samples_i[gi]};
        assign c_ext = {{DATA_W{coefs_i[gi][COEF_W-1]}}, coefs_i[gi]};
      end else begin : g_zext
        assign d_ext = {{COEF_W{1'b0}}, samples_i[gi]};
        assign c_ext = {{DATA_W{1'b0}}, coefs_i[gi]};
      end
      // With both operands pre-extended to PROD_W, the low PROD_W bits of
      // the product are exact for signed and unsigned alike.
      assign p = d_ext * c_ext;
      if (EXT_W > 0) begin : g_widen
        assign prod[gi] = {{EXT_W{SIGNED ? p[PROD_W-1] : 1'b0}}, p};
      end else begin : g_same
        assign prod[gi] = p;
      end
    end else begin : g_pad
      assign prod[gi] = '0;
    end
  end

  // Heap-ordered tree: leaves at LEAVES-1.., node k sums children 2k+1, 2k+2.
  always_comb begin
    for (int k = 0; k < LEAVES; k++) begin
      node[LEAVES-1+k] = prod[k];
    end
    for (int k = LEAVES - 2; k >= 0; k--) begin
      node[k] = node[2*k+1] + node[2*k+2];
    end
    sum_o = node[0];
  end

endmodule

// File: rtl/conv_stream_engine.sv
// conv_stream_engine: streaming full linear convolution y = x * h with a
// programmable kernel and automatic tail flush after the last input sample.
//   clk, rst_n                      - clock, asynchronous active-low reset
//   coef_we/coef_addr/coef_data     - kernel write port (honoured in IDLE only)
//   in_valid/in_ready/in_data/in_last     - sample input stream
//   out_valid/out_ready/out_data/out_last - result output stream
//   busy                            - high while a frame is in RUN or FLUSH
module conv_stream_engine
  import conv_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  COEF_W = 8,
  parameter int  TAPS   = 8,
  parameter bit  SIGNED = 1'b1,
  parameter int  ACC_W  = acc_width(DATA_W, COEF_W, TAPS),
  localparam int AW     = addr_width(TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy
);

  state_e                      state_q;
  logic [TAPS-1:0][COEF_W-1:0] coef_q;
  logic [TAPS-1:0][COEF_W-1:0] coef_d;
  logic [TAPS-1:0][DATA_W-1:0] dly_q;
  logic [TAPS-1:0][DATA_W-1:0] dly_d;
  logic [AW-1:0]               cnt_q;
  logic                        out_valid_q;
  logic                        out_last_q;
  logic [ACC_W-1:0]            out_data_q;
  logic [ACC_W-1:0]            mac_sum;

  logic slot_free;
  logic accept;
  logic flush_step;
  logic advance;
  logic coef_wr;
  logic last_out;

  assign slot_free  = !out_valid_q || out_ready;
  assign in_ready   = slot_free && (state_q != FLUSH);
  assign accept     = in_valid && in_ready;
  assign flush_step = slot_free && (state_q == FLUSH);
  assign advance    = accept || flush_step;
  assign coef_wr    = coef_we && (state_q == IDLE) &&
                      ({1'b0, coef_addr} < (AW+1)'(TAPS));
  // Final output of a frame: the in_last sample itself for a one-tap kernel,
  // otherwise the flush step where the counter reaches 1.
  assign last_out   = (accept && in_last && (TAPS == 1)) ||
                      (flush_step && (cnt_q == AW'(1)));

  // coef_d carries a same-cycle IDLE write so the first sample of a frame
  // already multiplies with the new coefficient. dly_d is the shifted line.
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_line
    assign coef_d[gi] = (coef_wr && (coef_addr == AW'(gi))) ? coef_data : coef_q[gi];
    if (gi == 0) begin : g_head
      assign dly_d[gi] = accept ? in_data : '0;
    end else begin : g_tail
      assign dly_d[gi] = dly_q[gi-1];
    end
  end

  conv_mac_tree #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .SIGNED (SIGNED),
    .ACC_W  (ACC_W)
  ) u_mac (
    .samples_i (dly_d),
    .coefs_i   (coef_d),
    .sum_o     (mac_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      coef_q      <= '0;
      dly_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      coef_q <= coef_d;

      if (advance) begin
        // Clearing the line at frame end drops the last sample, which would
        // otherwise still sit in the oldest tap for the next frame.
        dly_q       <= last_out ? '0 : dly_d;
        out_data_q  <= mac_sum;
        out_valid_q <= 1'b1;
        out_last_q  <= last_out;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE, RUN: begin
          if (accept) begin
            if (in_last && (TAPS > 1)) begin
              state_q <= FLUSH;
              cnt_q   <= AW'(TAPS - 1);
            end else if (in_last) begin
              state_q <= IDLE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        FLUSH: begin
          if (flush_step) begin
            cnt_q <= cnt_q - AW'(1);
            if (cnt_q == AW'(1)) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_stream_engine.sv
// Bench for conv_stream_engine: three instances (4-tap unsigned, 4-tap
// signed, 8-tap 1-bit) driven from one sequence of scenario tasks.
module tb_conv_stream_engine;

  typedef struct packed {
    logic [17:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_total = 0;
  int n_pass  = 0;

  // ---------------- instance A: TAPS=4, 8x8, unsigned ----------------
  logic        a_coef_we;
  logic [1:0]  a_coef_addr;
  logic [7:0]  a_coef_data;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [7:0]  a_in_data;
  logic        a_in_last;
  logic        a_out_valid;
  logic        a_out_ready = 1'b1;
  logic [17:0] a_out_data;
  logic        a_out_last;
  logic        a_busy;

  conv_stream_engine #(.DATA_W(8), .COEF_W(8), .TAPS(4), .SIGNED(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .coef_we(a_coef_we), .coef_addr(a_coef_addr), .coef_data(a_coef_data),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .busy(a_busy)
  );

  // ---------------- instance S: TAPS=4, 8x8, signed ----------------
  logic        s_coef_we;
  logic [1:0]  s_coef_addr;
  logic [7:0]  s_coef_data;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_in_data;
  logic        s_in_last;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [17:0] s_out_data;
  logic        s_out_last;
  logic        s_busy;

  conv_stream_engine #(.DATA_W(8), .COEF_W(8), .TAPS(4), .SIGNED(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n),
    .coef_we(s_coef_we), .coef_addr(s_coef_addr), .coef_data(s_coef_data),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .busy(s_busy)
  );

  // ---------------- instance B: TAPS=8, 1x1, unsigned ----------------
  logic        b_coef_we;
  logic [2:0]  b_coef_addr;
  logic [0:0]  b_coef_data;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [0:0]  b_in_data;
  logic        b_in_last;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [4:0]  b_out_data;
  logic        b_out_last;
  logic        b_busy;

  conv_stream_engine #(.DATA_W(1), .COEF_W(1), .TAPS(8), .SIGNED(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_data(b_coef_data),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy)
  );

  // ---------------- scoreboard and monitor for instance A ----------------
  exp_t        a_q[$];
  exp_t        mon_e;
  logic        mon_en     = 1'b0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_data  = '0;
  int          cyc        = 0;
  int          first_cyc  = -1;
  int          last_cyc   = -1;
  int          stall_cnt  = 0;

  logic        bp_en  = 1'b0;
  logic [1:0]  bp_idx = 2'd0;
  logic [3:0]  bp_pat = 4'b1001;   // out_ready sequence 1,0,0,1 (bit 0 first)

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    a_out_ready = bp_en ? bp_pat[bp_idx] : 1'b1;
    if (bp_en) bp_idx = bp_idx + 2'd1;
  end

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_total++;
        if (a_out_valid !== 1'b1 || a_out_data !== prev_data)
          $display("FAIL stall_hold: got valid=%b data=%0d, required valid=1 data=%0d",
                   a_out_valid, a_out_data, prev_data);
        else n_pass++;
      end
      if (a_out_valid && !a_out_ready) begin
        stall_cnt++;
        n_total++;
        if (a_in_ready !== 1'b0)
          $display("FAIL in_ready_stall: got %b, required 0", a_in_ready);
        else n_pass++;
      end
      if (a_out_valid && a_out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        n_total++;
        if (a_q.size() == 0) begin
          $display("FAIL a_unexpected: got data=%0d last=%b, required no output",
                   a_out_data, a_out_last);
        end else begin
          mon_e = a_q.pop_front();
          $display("[a] y=%0d last=%b (exp %0d/%b)", a_out_data, a_out_last, mon_e.data, mon_e.last);
          if (a_out_data !== mon_e.data || a_out_last !== mon_e.last)
            $display("FAIL a_output: got data=%0d last=%b, required data=%0d last=%b",
                     a_out_data, a_out_last, mon_e.data, mon_e.last);
          else n_pass++;
        end
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev_data  = a_out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic push_a(input int d, input logic l);
    a_q.push_back('{data: 18'(d), last: l});
  endtask

  task automatic load_coef_a(input logic [1:0] addr, input logic [7:0] data);
    a_coef_we = 1'b1; a_coef_addr = addr; a_coef_data = data;
    @(posedge clk); #1;
    a_coef_we = 1'b0;
  endtask

  // Presents one sample and holds it until accepted; bounded wait.
  task automatic send_a(input logic [7:0] d, input logic last);
    int guard;
    guard = 0;
    a_in_valid = 1'b1; a_in_data = d; a_in_last = last;
    @(negedge clk);
    while (a_in_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      n_total++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", a_in_ready);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_last = 1'b0;
  endtask

  // Full linear convolution by definition, h and x as bit vectors.
  function automatic int conv_ref(input logic [7:0] h, input logic [7:0] x, input int n);
    int acc;
    acc = 0;
    for (int k = 0; k < 8; k++)
      if (n - k >= 0 && n - k < 8) acc += int'(h[k] & x[n-k]);
    return acc;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", a_out_valid); else n_pass++;
    n_total++; if (a_out_data !== 18'd0) $display("FAIL reset_out_data: got %0d, required 0", a_out_data); else n_pass++;
    n_total++; if (a_out_last !== 1'b0) $display("FAIL reset_out_last: got %b, required 0", a_out_last); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", a_busy); else n_pass++;
    n_total++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", a_in_ready); else n_pass++;
    n_total++; if (s_out_valid !== 1'b0 || b_out_valid !== 1'b0)
      $display("FAIL reset_other_valid: got %b/%b, required 0/0", s_out_valid, b_out_valid); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) load_coef_a(2'(k), 8'(k + 1));
    first_cyc = -1;
    push_a(1, 1'b0); push_a(3, 1'b0); push_a(5, 1'b0); push_a(7, 1'b0); push_a(4, 1'b1);
    mon_en = 1'b1;
    send_a(8'd1, 1'b0);
    send_a(8'd1, 1'b1);
    for (int i = 0; i < 60 && a_q.size() != 0; i++) @(negedge clk);
    n_total++; if (a_q.size() != 0) $display("FAIL basic_drain: %0d outputs missing, required 0", a_q.size()); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (last_cyc - first_cyc != 4)
      $display("FAIL basic_consecutive: span %0d cycles, required 4", last_cyc - first_cyc); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL basic_busy_after: got %b, required 0", a_busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    stall_cnt = 0;
    bp_en = 1'b1;
    push_a(1, 1'b0); push_a(3, 1'b0); push_a(5, 1'b0); push_a(7, 1'b0); push_a(4, 1'b1);
    send_a(8'd1, 1'b0);
    send_a(8'd1, 1'b1);
    for (int i = 0; i < 80 && a_q.size() != 0; i++) @(negedge clk);
    n_total++; if (a_q.size() != 0) $display("FAIL bp_drain: %0d outputs missing, required 0", a_q.size()); else n_pass++;
    n_total++; if (stall_cnt == 0) $display("FAIL bp_stalls: got %0d stalled cycles, required >0", stall_cnt); else n_pass++;
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_coef_write();
    // Write during RUN is ignored for the whole frame.
    push_a(1, 1'b0); push_a(3, 1'b0); push_a(5, 1'b0); push_a(7, 1'b0); push_a(4, 1'b1);
    send_a(8'd1, 1'b0);
    a_coef_we = 1'b1; a_coef_addr = 2'd0; a_coef_data = 8'd9;
    send_a(8'd1, 1'b1);
    a_coef_we = 1'b0;
    for (int i = 0; i < 60 && a_q.size() != 0; i++) @(negedge clk);
    n_total++; if (a_q.size() != 0) $display("FAIL run_write_drain: %0d outputs missing, required 0", a_q.size()); else n_pass++;
    @(posedge clk); #1;
    // Write in IDLE applies to the next frame.
    load_coef_a(2'd0, 8'd9);
    push_a(9, 1'b0); push_a(2, 1'b0); push_a(3, 1'b0); push_a(4, 1'b1);
    send_a(8'd1, 1'b1);
    for (int i = 0; i < 60 && a_q.size() != 0; i++) @(negedge clk);
    n_total++; if (a_q.size() != 0) $display("FAIL idle_write_drain: %0d outputs missing, required 0", a_q.size()); else n_pass++;
    @(posedge clk); #1;
    // Write coinciding with the first accept is used by that sample.
    push_a(5, 1'b0); push_a(2, 1'b0); push_a(3, 1'b0); push_a(4, 1'b1);
    a_coef_we = 1'b1; a_coef_addr = 2'd0; a_coef_data = 8'd5;
    send_a(8'd1, 1'b1);
    a_coef_we = 1'b0;
    for (int i = 0; i < 60 && a_q.size() != 0; i++) @(negedge clk);
    n_total++; if (a_q.size() != 0) $display("FAIL same_cycle_drain: %0d outputs missing, required 0", a_q.size()); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_flush();
    mon_en = 1'b0;
    a_q.delete();
    send_a(8'd5, 1'b0);
    send_a(8'd5, 1'b1);
    @(negedge clk);
    n_total++; if (a_busy !== 1'b1) $display("FAIL flush_busy: got %b, required 1", a_busy); else n_pass++;
    n_total++; if (a_in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b, required 0", a_in_ready); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL midrst_valid: got %b, required 0", a_out_valid); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL midrst_busy: got %b, required 0", a_busy); else n_pass++;
    n_total++; if (a_out_data !== 18'd0) $display("FAIL midrst_data: got %0d, required 0", a_out_data); else n_pass++;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Kernel is cleared by reset: four zero outputs, last on the fourth.
    push_a(0, 1'b0); push_a(0, 1'b0); push_a(0, 1'b0); push_a(0, 1'b1);
    mon_en = 1'b1;
    send_a(8'd1, 1'b1);
    for (int i = 0; i < 60 && a_q.size() != 0; i++) @(negedge clk);
    n_total++; if (a_q.size() != 0) $display("FAIL post_rst_drain: %0d outputs missing, required 0", a_q.size()); else n_pass++;
    @(posedge clk); #1;
    mon_en = 1'b0;
  endtask

  task automatic test_signed();
    exp_t s_q[$];
    exp_t e;
    s_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_coef_we = 1'b1; s_coef_addr = 2'(k); s_coef_data = 8'h80;
      @(posedge clk); #1;
    end
    s_coef_we = 1'b0;
    for (int k = 0; k < 4; k++) s_q.push_back('{data: 18'd16384, last: (k == 3)});
    fork
      begin
        s_in_valid = 1'b1; s_in_data = 8'h80; s_in_last = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_in_last = 1'b0;
      end
      begin
        for (int i = 0; i < 40 && s_q.size() != 0; i++) begin
          @(negedge clk);
          if (s_out_valid && s_out_ready) begin
            e = s_q.pop_front();
            $display("[s] y=%0d last=%b (exp %0d/%b)", s_out_data, s_out_last, e.data, e.last);
            n_total++;
            if (s_out_data !== e.data || s_out_last !== e.last)
              $display("FAIL signed_output: got data=%0d last=%b, required data=%0d last=%b",
                       s_out_data, s_out_last, e.data, e.last);
            else n_pass++;
          end
        end
      end
    join
    n_total++; if (s_q.size() != 0) $display("FAIL signed_drain: %0d outputs missing, required 0", s_q.size()); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (s_busy !== 1'b0) $display("FAIL signed_busy_after: got %b, required 0", s_busy); else n_pass++;
  endtask

  task automatic test_back_to_back_legacy();
    exp_t b_q[$];
    exp_t e;
    logic [7:0] h_bits;
    logic [7:0] x_bits;
    int sum;
    h_bits = 8'b0000_1001;
    x_bits = 8'hFF;
    sum = 0;
    b_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b_coef_we = 1'b1; b_coef_addr = 3'(k); b_coef_data = h_bits[k];
      @(posedge clk); #1;
    end
    b_coef_we = 1'b0;
    for (int n = 0; n < 15; n++) b_q.push_back('{data: 18'(conv_ref(h_bits, x_bits, n)), last: (n == 14)});
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          b_in_valid = 1'b1; b_in_data = x_bits[i]; b_in_last = (i == 7);
          @(posedge clk); #1;
        end
        b_in_valid = 1'b0; b_in_last = 1'b0;
      end
      begin
        for (int i = 0; i < 60 && b_q.size() != 0; i++) begin
          @(negedge clk);
          if (b_out_valid && b_out_ready) begin
            e = b_q.pop_front();
            sum += int'(b_out_data);
            $display("[b] y=%0d last=%b (exp %0d/%b)", b_out_data, b_out_last, e.data, e.last);
            n_total++;
            if ({13'd0, b_out_data} !== e.data || b_out_last !== e.last)
              $display("FAIL legacy_output: got data=%0d last=%b, required data=%0d last=%b",
                       b_out_data, b_out_last, e.data, e.last);
            else n_pass++;
          end
        end
      end
    join
    n_total++; if (b_q.size() != 0) $display("FAIL legacy_drain: %0d outputs missing, required 0", b_q.size()); else n_pass++;
    n_total++; if (sum != 16) $display("FAIL legacy_sum: got %0d, required 16", sum); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_coef_we = 1'b0; a_coef_addr = '0; a_coef_data = '0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0;
    s_coef_we = 1'b0; s_coef_addr = '0; s_coef_data = '0;
    s_in_valid = 1'b0; s_in_data = '0; s_in_last = 1'b0; s_out_ready = 1'b1;
    b_coef_we = 1'b0; b_coef_addr = '0; b_coef_data = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    test_reset();
    test_basic();
    test_backpressure();
    test_coef_write();
    test_reset_flush();
    test_signed();
    test_back_to_back_legacy();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
